mc_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder of the 8-bit MIPS core.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and issues the per-state datapath strobes.
- Holds in memory states until a memory ready handshake arrives, with a timeout.
- Flags illegal opcodes and counts retired instructions; sits between the instruction register and the shared-memory datapath.

---
 rtl/mc_ctrl_pkg.sv | 39 +++
 rtl/mc_control_unit_mc_wait_timer.sv | 32 +++
 rtl/mc_control_unit.sv | 172 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode and strobe types for the multi-cycle control unit
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_BR,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_I,
    WB_MEM,
    HALT
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LB   = 3'b010;
  localparam logic [2:0] OP_SB   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;

  typedef struct packed {
    logic pc_write;
    logic ir_write;
    logic iord;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic mem_to_reg;
    logic reg_write;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/mc_control_unit_mc_wait_timer.sv
// rtl/mc_control_unit_mc_wait_timer.sv - memory wait counter and timeout detect
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_mem,
  input  logic mem_ready,
  output logic timeout
);

  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
  localparam logic ENABLE = (MEM_TIMEOUT > 0);

  logic [W-1:0] wait_cnt_q, wait_cnt_d;

  // Holding at zero outside memory states gives the clear-on-entry behaviour for free.
  always_comb begin
    wait_cnt_d = wait_cnt_q + W'(1);
    if (!in_mem || mem_ready) wait_cnt_d = '0;
  end

  // Fires on the last permitted waiting cycle; a same-cycle mem_ready wins.
  assign timeout = ENABLE && in_mem && !mem_ready && (wait_cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit MIPS core
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic                illegal_op,
  output logic                mem_err,
  output logic                retire,
  output logic [CNT_W-1:0]    retire_cnt
);

  state_t           state_q, state_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  ctrl_t            ctrl, ctrl_o;
  logic             illegal_c, retire_c, in_mem, timeout;
  logic [2:0]       op3;
  logic             op_bad;

  assign op3    = opcode[2:0];
  assign op_bad = ((opcode >> 3) != '0) || (op3[2:1] == 2'b11);
  assign in_mem = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .in_mem   (in_mem),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    illegal_c = 1'b0;
    retire_c  = 1'b0;
    case (state_q)
      FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = DECODE;
        end else if (timeout) begin
          state_d = HALT;
        end
      end
      DECODE: begin
        if (op_bad) begin
          illegal_c = 1'b1;
          state_d   = FETCH;
        end else begin
          case (op3)
            OP_J: begin
              ctrl.jump     = 1'b1;
              ctrl.pc_write = 1'b1;
              retire_c      = 1'b1;
              state_d       = FETCH;
            end
            OP_R:    state_d = EXEC_R;
            OP_BEQ:  state_d = EXEC_BR;
            default: state_d = EXEC_I;
          endcase
        end
      end
      EXEC_R: state_d = WB_R;
      EXEC_I: begin
        ctrl.alu_src = 1'b1;
        case (op3)
          OP_LB:   state_d = MEM_RD;
          OP_SB:   state_d = MEM_WR;
          default: state_d = WB_I;
        endcase
      end
      EXEC_BR: begin
        ctrl.branch = 1'b1;
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.alu_src  = 1'b1;
        if (mem_ready)    state_d = WB_MEM;
        else if (timeout) state_d = HALT;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.alu_src   = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (timeout) begin
          state_d = HALT;
        end
      end
      WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        retire_c       = 1'b1;
        state_d        = FETCH;
      end
      WB_I: begin
        ctrl.reg_write = 1'b1;
        retire_c       = 1'b1;
        state_d        = FETCH;
      end
      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire_c        = 1'b1;
        state_d         = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    mem_err_d    = mem_err_q | timeout;
    retire_cnt_d = retire_c ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      mem_err_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_err_q    <= mem_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Decode is combinational from FETCH, so gate everything while reset is held.
  assign ctrl_o     = reset_n ? ctrl : '0;
  assign pc_write   = ctrl_o.pc_write;
  assign ir_write   = ctrl_o.ir_write;
  assign iord       = ctrl_o.iord;
  assign mem_read   = ctrl_o.mem_read;
  assign mem_write  = ctrl_o.mem_write;
  assign alu_src    = ctrl_o.alu_src;
  assign reg_dst    = ctrl_o.reg_dst;
  assign mem_to_reg = ctrl_o.mem_to_reg;
  assign reg_write  = ctrl_o.reg_write;
  assign branch     = ctrl_o.branch;
  assign jump       = ctrl_o.jump;
  assign illegal_op = reset_n & illegal_c;
  assign retire     = reset_n & retire_c;
  assign mem_err    = mem_err_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized instruction-level check of mc_control_unit
module tb_mc_control_unit;

  localparam int OPW = 4;
  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [12:0] V_PCW  = 13'h1000;
  localparam logic [12:0] V_IRW  = 13'h0800;
  localparam logic [12:0] V_IORD = 13'h0400;
  localparam logic [12:0] V_MRD  = 13'h0200;
  localparam logic [12:0] V_MWR  = 13'h0100;
  localparam logic [12:0] V_ALU  = 13'h0080;
  localparam logic [12:0] V_RD   = 13'h0040;
  localparam logic [12:0] V_MTR  = 13'h0020;
  localparam logic [12:0] V_RW   = 13'h0010;
  localparam logic [12:0] V_BR   = 13'h0008;
  localparam logic [12:0] V_JMP  = 13'h0004;
  localparam logic [12:0] V_ILL  = 13'h0002;
  localparam logic [12:0] V_RET  = 13'h0001;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic pc_write, ir_write, iord, mem_read, mem_write, alu_src, reg_dst;
  logic mem_to_reg, reg_write, branch, jump, illegal_op, mem_err, retire;
  logic [CW-1:0]  retire_cnt;
  logic [12:0]    got;

  int n_chk  = 0;
  int n_pass = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  mc_control_unit #(
    .OPCODE_W(OPW), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch), .jump(jump),
    .illegal_op(illegal_op), .mem_err(mem_err), .retire(retire), .retire_cnt(retire_cnt)
  );

  assign got = {pc_write, ir_write, iord, mem_read, mem_write, alu_src, reg_dst,
                mem_to_reg, reg_write, branch, jump, illegal_op, retire};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Entered at a negedge: drive mem_ready (2 = don't care, randomized), check, advance one cycle.
  task automatic step(input int rdy, input logic [12:0] exp, input string tag);
    mem_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
    #1 check(tag, 32'(got), 32'(exp));
    if ((exp & V_RET) != 0) model_cnt++;
    @(negedge clk);
  endtask

  // Expected per-cycle strobes derived from the instruction class table.
  task automatic run_instr(input logic [OPW-1:0] op, input int wf, input int wm);
    logic [12:0] exp_q[$];
    int          rdy_q[$];
    for (int i = 0; i < wf; i++) begin exp_q.push_back(V_MRD); rdy_q.push_back(0); end
    exp_q.push_back(V_MRD | V_IRW | V_PCW); rdy_q.push_back(1);
    if (op > 5) begin
      exp_q.push_back(V_ILL); rdy_q.push_back(2);
    end else begin
      case (op)
        0: begin exp_q = {exp_q, 13'h0, 13'h0, V_RW | V_RD | V_RET}; rdy_q = {rdy_q, 2, 2, 2}; end
        1: begin exp_q = {exp_q, 13'h0, V_ALU, V_RW | V_RET}; rdy_q = {rdy_q, 2, 2, 2}; end
        2: begin
          exp_q = {exp_q, 13'h0, V_ALU}; rdy_q = {rdy_q, 2, 2};
          for (int i = 0; i <= wm; i++) begin
            exp_q.push_back(V_MRD | V_IORD | V_ALU); rdy_q.push_back(i == wm ? 1 : 0);
          end
          exp_q.push_back(V_RW | V_MTR | V_RET); rdy_q.push_back(2);
        end
        3: begin
          exp_q = {exp_q, 13'h0, V_ALU}; rdy_q = {rdy_q, 2, 2};
          for (int i = 0; i <= wm; i++) begin
            exp_q.push_back(V_MWR | V_IORD | V_ALU | (i == wm ? V_RET : 13'h0));
            rdy_q.push_back(i == wm ? 1 : 0);
          end
        end
        4: begin exp_q = {exp_q, 13'h0, V_BR | V_RET}; rdy_q = {rdy_q, 2, 2}; end
        default: begin exp_q.push_back(V_JMP | V_PCW | V_RET); rdy_q.push_back(2); end
      endcase
    end
    opcode = op;
    foreach (exp_q[i]) step(rdy_q[i], exp_q[i], $sformatf("op%0d_cyc%0d", op, i));
    check("retire_cnt", 32'(retire_cnt), 32'(model_cnt % (1 << CW)));
    check("mem_err_clear", 32'(mem_err), 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 check("rst_strobes", 32'(got), 0);
    check("rst_cnt", 32'(retire_cnt), 0);
    check("rst_err", 32'(mem_err), 0);
    @(negedge clk);
    reset_n   = 1'b1;
    model_cnt = 0;
  endtask

  initial begin
    opcode = '0;
    do_reset();

    run_instr(4'd0, 0, 0);
    run_instr(4'd2, 0, 3);
    run_instr(4'd5, 0, 0);
    run_instr(4'd4, 0, 0);
    run_instr(4'd7, 0, 0);
    run_instr(4'd9, 0, 0);
    run_instr(4'd1, 3, 0);
    run_instr(4'd3, 3, 3);

    for (int n = 0; n < 60; n++) begin
      logic [OPW-1:0] op;
      op = ($urandom_range(0, 3) == 0) ? OPW'($urandom_range(6, 15)) : OPW'($urandom_range(0, 5));
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a store.
    opcode = 4'd3;
    step(1, V_MRD | V_IRW | V_PCW, "sb_fetch");
    step(2, 13'h0, "sb_decode");
    step(2, V_ALU, "sb_exec");
    mem_ready = 1'b0;
    #1 check("mid_wr_mem_write", 32'(mem_write), 1);
    reset_n = 1'b0;
    #1 check("mid_wr_reset_drop", 32'(got), 0);
    @(negedge clk);
    check("mid_wr_cnt", 32'(retire_cnt), 0);
    reset_n   = 1'b1;
    model_cnt = 0;
    step(0, V_MRD, "post_rst_fetch");

    for (int n = 0; n < (1 << CW); n++) run_instr(4'd5, 0, 0);
    check("cnt_wrap", 32'(retire_cnt), 0);

    // Fetch timeout.
    do_reset();
    opcode = 4'd0;
    for (int i = 0; i < TMO; i++) begin
      check("err_before_tmo", 32'(mem_err), 0);
      step(0, V_MRD, "tmo_wait");
    end
    for (int i = 0; i < 4; i++) begin
      check("halt_err", 32'(mem_err), 1);
      step(2, 13'h0, "halt_strobes");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
